// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a first-word-fall-through byte FIFO and sticky error flags.
// The FSM state and its sample strobe are exported on dbg_state/dbg_tick for observation.
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          core_clk,
  input  logic                          core_rstn,
  input  logic                          enable,
  input  logic [DIV_WIDTH-1:0]          divisor,
  input  logic                          ser_rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          err_clr,
  output logic [2:0]                    dbg_state,
  output logic                          dbg_tick
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_rxs_d;
  logic [DIV_WIDTH-1:0]  r_cnt;
  logic [DIV_WIDTH-1:0]  w_cnt_nxt;
  logic [DIV_WIDTH-1:0]  r_div;
  logic [DIV_WIDTH-1:0]  w_div_nxt;
  logic [DIV_WIDTH-1:0]  w_eff_div;
  logic [7:0]            r_shift;
  logic [7:0]            w_shift_nxt;
  logic [2:0]            r_bit;
  logic [2:0]            w_bit_nxt;
  logic                  w_rxs;
  logic                  w_tick;
  logic                  w_push;
  logic                  w_frame_set;

  logic [7:0]            r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr;
  logic [PTR_W-1:0]      r_rd;
  logic [LVL_W-1:0]      r_level;
  logic                  w_valid;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_wr;
  logic                  w_ovr_set;

  assign w_rxs     = r_sync2;
  assign w_eff_div = (divisor < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : divisor;
  assign w_tick    = (r_cnt == '0);

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rxs_d <= 1'b1;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_div   <= DIV_WIDTH'(4);
      r_shift <= '0;
      r_bit   <= '0;
    end else begin
      r_sync1 <= ser_rx;
      r_sync2 <= r_sync1;
      r_rxs_d <= r_sync2;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_div   <= w_div_nxt;
      r_shift <= w_shift_nxt;
      r_bit   <= w_bit_nxt;
    end
  end

  // Counter is loaded with (period - 1) so a sample lands exactly every period cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_div_nxt   = r_div;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit;
    w_push      = 1'b0;
    w_frame_set = 1'b0;
    if (!enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_rxs_d && !w_rxs) begin
            w_state_nxt = S_START;
            w_div_nxt   = w_eff_div;
            w_cnt_nxt   = (w_eff_div >> 1) - DIV_WIDTH'(1);
          end
        end
        S_START: begin
          if (w_tick) begin
            if (!w_rxs) begin
              w_state_nxt = S_DATA;
              w_cnt_nxt   = r_div - DIV_WIDTH'(1);
              w_bit_nxt   = '0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt - DIV_WIDTH'(1);
          end
        end
        S_DATA: begin
          if (w_tick) begin
            w_shift_nxt = {w_rxs, r_shift[7:1]};
            w_cnt_nxt   = r_div - DIV_WIDTH'(1);
            w_bit_nxt   = r_bit + 3'd1;
            if (r_bit == 3'd7) w_state_nxt = S_STOP;
          end else begin
            w_cnt_nxt = r_cnt - DIV_WIDTH'(1);
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (w_rxs) begin
              w_push      = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_frame_set = 1'b1;
              w_state_nxt = S_BREAK;
            end
          end else begin
            w_cnt_nxt = r_cnt - DIV_WIDTH'(1);
          end
        end
        S_BREAK: begin
          if (w_rxs) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_valid   = (r_level != '0);
  assign w_full    = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_pop     = w_valid && rx_ready;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_ovr_set = w_push && w_full && !w_pop;

  always_ff @(posedge core_clk) begin
    if (w_wr) r_mem[r_wr] <= r_shift;
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      r_wr      <= '0;
      r_rd      <= '0;
      r_level   <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (w_wr)  r_wr <= r_wr + PTR_W'(1);
      if (w_pop) r_rd <= r_rd + PTR_W'(1);
      if (w_wr && !w_pop)      r_level <= r_level + LVL_W'(1);
      else if (!w_wr && w_pop) r_level <= r_level - LVL_W'(1);
      if (w_frame_set)  frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (w_ovr_set)    overrun <= 1'b1;
      else if (err_clr) overrun <= 1'b0;
    end
  end

  // Head is masked while empty so stale or unwritten entries never reach the port.
  assign rx_data    = w_valid ? r_mem[r_rd] : 8'h00;
  assign rx_valid   = w_valid;
  assign fifo_level = r_level;
  assign dbg_state  = r_state;
  assign dbg_tick   = w_tick && (r_state == S_START || r_state == S_DATA || r_state == S_STOP);

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Synthesizable UART receiver for the management SoC. It takes the serial line driven on the user-project pad by the loopback or the testbench UART driver, and decodes 8N1 frames. Good bytes are buffered in a small first-word-fall-through FIFO that firmware or wishbone glue drains through a valid/ready handshake. Framing and overrun conditions are reported as sticky flags so firmware can raise a failure pattern on the checkbits.

Parameters:
FIFO_DEPTH, 16, number of byte entries; must be a power of 2, minimum 2.
DIV_WIDTH, 16, width of the bit-period divisor input.

Ports:
core_clk  input  1  system clock
core_rstn  input  1  asynchronous active-low reset
enable  input  1  receiver enable; low forces IDLE
divisor  input  DIV_WIDTH  core_clk cycles per bit; values below 4 are treated as 4
ser_rx  input  1  asynchronous serial input, idle high
rx_data  output  8  FIFO head byte
rx_valid  output  1  FIFO non-empty
rx_ready  input  1  consumer pop strobe; pops when rx_valid and rx_ready are both high
fifo_level  output  $clog2(FIFO_DEPTH)+1  current entry count
frame_err  output  1  sticky: stop bit sampled low
overrun  output  1  sticky: byte received while FIFO full
err_clr  input  1  clears frame_err and overrun

Behaviour:
- Reset (async, core_rstn low): state IDLE, FIFO empty, rx_valid=0, rx_data=0, fifo_level=0, frame_err=0, overrun=0, synchronizer flops=1.
- ser_rx passes through a 2-flop synchronizer; all decisions use the synchronized value (rxs).
- Bit counter is loaded with the effective divisor (eff_div = max(divisor,4)). divisor is sampled at start-bit detection and held for the whole frame.
- FSM states:
  - IDLE: on a falling edge of rxs (previous 1, current 0) with enable=1, go to START and load the counter with eff_div>>1.
  - START: count down to 0. If rxs=0, go to DATA and load eff_div. If rxs=1, treat as a false start and return to IDLE with no flag.
  - DATA: eight samples, each after eff_div cycles, shifted in LSB first. After bit 7, go to STOP.
  - STOP: sample after eff_div cycles.
    - rxs=1: byte is good. Push it if the FIFO is not full; otherwise drop it and set overrun. Go to IDLE.
    - rxs=0: drop the byte, set frame_err, go to BREAK.
  - BREAK: wait until rxs=1, then go to IDLE. A held-low line (break) produces exactly one frame_err.
- enable low: FSM returns to IDLE on the next cycle and any partial byte is discarded. FIFO contents and flags are kept. Pops remain legal.
- Latency: rx_valid rises on the cycle after the STOP sample cycle (push registered).
- FIFO:
  - First-word fall-through: rx_data always shows the head entry when rx_valid=1. rx_data is don't-care while empty but must not go X after reset.
  - Pointers wrap modulo FIFO_DEPTH. fifo_level tracks the count, 0 to FIFO_DEPTH.
  - Push and pop in the same cycle: both happen, and level is unchanged.
  - Push on a full FIFO with a same-cycle pop: the push succeeds and no overrun is flagged.
  - Pop while empty: ignored.
- Flags are sticky until err_clr=1. If err_clr and a new set event land in the same cycle, set wins.
- Reset mid-frame: everything returns to reset values immediately. The next start bit is detected normally after release.

Test Plan:
- divisor=16. Send 0x55 then 0xA3 with 8N1 at 16 cycles/bit. Expected: rx_valid rises 1 cycle after each stop sample, rx_data=0x55 then 0xA3 after a pop, fifo_level goes 1→2→1→0, no flags.
- divisor=16. Drive a 5-cycle low glitch on ser_rx. Expected: no byte pushed, no flag, FSM back in IDLE.
- divisor=16. Send 0x3C with the stop bit low, then hold the line low for 40 bit periods. Expected: frame_err=1 exactly once, fifo_level=0. After the line returns high, a following 0x81 frame is received correctly. err_clr clears frame_err.
- FIFO_DEPTH=16, rx_ready=0. Send bytes 0x00..0x10 (17 bytes). Expected: fifo_level=16, overrun=1, popped sequence is 0x00..0x0F and 0x10 is absent.
- divisor=2. Expected: bit period is 4 cycles (clamp), and byte 0xF0 is received correctly. In the same test, with FIFO full, complete a frame while asserting rx_ready in the push cycle: expected no overrun, level stays 16.
- Assert core_rstn low during DATA bit 4 of a frame. Expected: all outputs return to reset values asynchronously. After release, 0x7E is received correctly.
